// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run-detect FSM blocks.
// Provides the default counter width and the IDLE/RUN state enumeration.
package run_monitor_pkg;

    localparam int unsigned DefaultW = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } run_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear, highest priority
//   load  - load the value 1 (start of a new count)
//   inc   - increment, holding at all-ones once reached
//   cnt   - registered count value
module sat_counter
    import run_monitor_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = W'(1);
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/run_monitor.sv
// Run monitor: measures runs of the upstream run-detect flag z and reports
// each completed run as a length record over a valid/ready output.
// Ports:
//   clk, reset - clock and asynchronous active-low reset
//   z          - run-detect flag (synchronous to clk)
//   clr        - synchronous clear of all statistics and output state
//   out_ready  - downstream accepts the record held in out_len
//   out_valid  - out_len holds an unconsumed record
//   out_len    - length of the last accepted completed run
//   event_cnt  - runs started since reset/clr (saturating)
//   cur_len    - length of the current (or most recent) run (saturating)
//   max_len    - longest completed run since reset/clr
//   drop       - sticky: a completed record arrived while the output was full
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         z,
    input  logic         clr,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_len,
    output logic [W-1:0] event_cnt,
    output logic [W-1:0] cur_len,
    output logic [W-1:0] max_len,
    output logic         drop
);

    run_state_e   state_q, state_d;
    logic         run_start;
    logic         run_cont;
    logic         rec_valid;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_len_q, out_len_d;
    logic [W-1:0] max_len_q, max_len_d;
    logic         drop_q, drop_d;

    // FSM next-state; clr forces IDLE and suppresses all run events.
    always_comb begin
        state_d   = state_q;
        run_start = 1'b0;
        run_cont  = 1'b0;
        rec_valid = 1'b0;
        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (z) begin
                        run_start = 1'b1;
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    if (z) begin
                        run_cont = 1'b1;
                    end else begin
                        rec_valid = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Record path. cur_len still holds the finished run's length on the
    // RUN->IDLE edge, so it is the record value.
    always_comb begin
        out_valid_d = out_valid_q;
        out_len_d   = out_len_q;
        max_len_d   = max_len_q;
        drop_d      = drop_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_len_d   = '0;
            max_len_d   = '0;
            drop_d      = 1'b0;
        end else if (rec_valid) begin
            if (cur_len > max_len_q) begin
                max_len_d = cur_len;
            end
            if (!out_valid_q || out_ready) begin
                out_len_d   = cur_len;
                out_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_len_q   <= '0;
            max_len_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_len_q   <= out_len_d;
            max_len_q   <= max_len_d;
            drop_q      <= drop_d;
        end
    end

    sat_counter #(
        .W (W)
    ) u_event_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (1'b0),
        .inc   (run_start),
        .cnt   (event_cnt)
    );

    sat_counter #(
        .W (W)
    ) u_cur_len (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (run_start),
        .inc   (run_cont),
        .cnt   (cur_len)
    );

    assign out_valid = out_valid_q;
    assign out_len   = out_len_q;
    assign max_len   = max_len_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed scenarios plus a randomized
// phase, all compared against a run-level behavioural model.
module tb_run_monitor;

    localparam int unsigned W   = 8;
    localparam int          MAX = 255;

    logic         clk = 1'b0;
    logic         reset;
    logic         z;
    logic         clr;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_len;
    logic [W-1:0] event_cnt;
    logic [W-1:0] cur_len;
    logic [W-1:0] max_len;
    logic         drop;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (plain integers).
    bit m_in_run;
    int m_cur, m_ev, m_max, m_olen;
    bit m_ov, m_drop;

    int seen_len[$];

    run_monitor #(
        .W (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_len   (out_len),
        .event_cnt (event_cnt),
        .cur_len   (cur_len),
        .max_len   (max_len),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_in_run = 0;
        m_cur    = 0;
        m_ev     = 0;
        m_max    = 0;
        m_olen   = 0;
        m_ov     = 0;
        m_drop   = 0;
    endtask

    // One clock of the run-level rules, using the inputs seen at the edge.
    task automatic model_edge(input bit zv, input bit rv, input bit cv);
        int rec;
        bit have_rec;
        have_rec = 0;
        rec      = 0;
        if (cv) begin
            model_clear();
            return;
        end
        if (!m_in_run && zv) begin
            m_in_run = 1;
            m_cur    = 1;
            m_ev     = (m_ev + 1 > MAX) ? MAX : m_ev + 1;
        end else if (m_in_run && zv) begin
            m_cur = (m_cur + 1 > MAX) ? MAX : m_cur + 1;
        end else if (m_in_run && !zv) begin
            m_in_run = 0;
            have_rec = 1;
            rec      = m_cur;
        end
        if (have_rec) begin
            if (rec > m_max) m_max = rec;
            if (!m_ov || rv) begin
                m_olen = rec;
                m_ov   = 1;
            end else begin
                m_drop = 1;
            end
        end else if (m_ov && rv) begin
            m_ov = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".out_len"},   32'(out_len),   32'(m_olen));
        check({tag, ".event_cnt"}, 32'(event_cnt), 32'(m_ev));
        check({tag, ".cur_len"},   32'(cur_len),   32'(m_cur));
        check({tag, ".max_len"},   32'(max_len),   32'(m_max));
        check({tag, ".drop"},      32'(drop),      32'(m_drop));
    endtask

    // Drive inputs, take one clock edge, sample 1 time unit later.
    task automatic step(input bit zv, input bit rv, input bit cv, input string tag);
        z         = zv;
        out_ready = rv;
        clr       = cv;
        @(posedge clk);
        model_edge(zv, rv, cv);
        #1;
        compare_all(tag);
        if (out_valid) seen_len.push_back(int'(out_len));
    endtask

    task automatic run(input int len, input bit rv, input string tag);
        for (int i = 0; i < len; i++) step(1'b1, rv, 1'b0, tag);
        step(1'b0, rv, 1'b0, tag);
    endtask

    initial begin
        reset     = 1'b0;
        z         = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #3;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single 5-cycle run, consumer always ready.
        run(5, 1'b1, "run5");
        check("run5.valid_hi", 32'(out_valid), 32'd1);
        check("run5.len", 32'(out_len), 32'd5);
        check("run5.ev", 32'(event_cnt), 32'd1);
        check("run5.max", 32'(max_len), 32'd5);
        step(1'b0, 1'b1, 1'b0, "run5_after");
        check("run5.valid_1cyc", 32'(out_valid), 32'd0);

        // Three runs 3,7,4 with a ready consumer.
        step(1'b0, 1'b1, 1'b1, "clr1");
        seen_len.delete();
        run(3, 1'b1, "seq");
        run(7, 1'b1, "seq");
        run(4, 1'b1, "seq");
        step(1'b0, 1'b1, 1'b0, "seq_tail");
        check("seq.count", 32'(seen_len.size()), 32'd3);
        if (seen_len.size() == 3) begin
            check("seq.len0", 32'(seen_len[0]), 32'd3);
            check("seq.len1", 32'(seen_len[1]), 32'd7);
            check("seq.len2", 32'(seen_len[2]), 32'd4);
        end
        check("seq.max", 32'(max_len), 32'd7);
        check("seq.ev", 32'(event_cnt), 32'd3);
        check("seq.drop", 32'(drop), 32'd0);

        // Stalled consumer: second record is dropped.
        step(1'b0, 1'b1, 1'b1, "clr2");
        run(2, 1'b0, "stall");
        run(6, 1'b0, "stall");
        check("stall.len", 32'(out_len), 32'd2);
        check("stall.drop", 32'(drop), 32'd1);
        check("stall.max", 32'(max_len), 32'd6);
        check("stall.valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, "stall_hs");
        check("stall.valid_after", 32'(out_valid), 32'd0);

        // Record arrives on the same edge the held one is consumed.
        step(1'b0, 1'b1, 1'b1, "clr3");
        run(3, 1'b1, "b2b");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "b2b");
        step(1'b0, 1'b1, 1'b0, "b2b_end");
        check("b2b.len", 32'(out_len), 32'd4);
        check("b2b.valid", 32'(out_valid), 32'd1);
        check("b2b.drop", 32'(drop), 32'd0);

        // Saturation of cur_len and event_cnt.
        step(1'b0, 1'b1, 1'b1, "clr4");
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, "sat_len");
        check("sat.cur", 32'(cur_len), 32'd255);
        step(1'b0, 1'b1, 1'b0, "sat_rec");
        check("sat.out_len", 32'(out_len), 32'd255);
        step(1'b0, 1'b1, 1'b1, "clr5");
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b1, 1'b0, "pulse");
            step(1'b0, 1'b1, 1'b0, "pulse");
        end
        check("sat.ev", 32'(event_cnt), 32'd255);
        check("pulse.len", 32'(out_len), 32'd1);

        // Asynchronous reset mid-run discards the run.
        step(1'b0, 1'b1, 1'b1, "clr6");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "pre_rst");
        check("pre_rst.cur", 32'(cur_len), 32'd3);
        reset = 1'b0;
        #1;
        model_clear();
        compare_all("async_rst");
        #1;
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, "post_rst");
        check("post_rst.no_rec", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, "post_rst_start");
        check("post_rst.ev", 32'(event_cnt), 32'd1);
        check("post_rst.cur", 32'(cur_len), 32'd1);

        // Synchronous clear mid-run, z held high through the clear.
        step(1'b1, 1'b1, 1'b0, "pre_clr");
        step(1'b1, 1'b1, 1'b0, "pre_clr");
        step(1'b1, 1'b1, 1'b1, "clr_mid");
        check("clr_mid.cur", 32'(cur_len), 32'd0);
        check("clr_mid.ev", 32'(event_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
